// File: rtl/l2_line_responder_pkg.sv
// Shared types and constants for the L2 line responder.
// Holds the AXI4 slave channel structs, the FSM state encoding, the
// responder register set with its reset value, and small geometry helpers.
package l2_line_responder_pkg;

    localparam int CFG_SYSBUS_ADDR_BITS = 48;
    localparam int L2CACHE_LINE_BITS    = 256;
    localparam int CFG_SYSBUS_DATA_BITS = 64;

    localparam int ABITS     = CFG_SYSBUS_ADDR_BITS;
    localparam int LINEW     = L2CACHE_LINE_BITS;
    localparam int BUSW      = CFG_SYSBUS_DATA_BITS;
    localparam int LINEB     = LINEW / 8;
    localparam int BUSB      = BUSW / 8;
    localparam int BURST_LEN = LINEB / BUSB;
    localparam int LINE_OFS  = $clog2(LINEB);
    localparam int BUS_OFS   = $clog2(BUSB);
    localparam int IDX_BITS  = LINE_OFS - BUS_OFS;
    localparam int ID_BITS   = 5;
    localparam int USER_BITS = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WDATA     = 3'd1,
        ST_LINE_REQ  = 3'd2,
        ST_LINE_RESP = 3'd3,
        ST_BRESP     = 3'd4,
        ST_RBURST    = 3'd5
    } state_t;

    typedef struct packed {
        logic                 aw_valid;
        logic [ABITS-1:0]     aw_addr;
        logic [7:0]           aw_len;
        logic [1:0]           aw_burst;
        logic [ID_BITS-1:0]   aw_id;
        logic [USER_BITS-1:0] aw_user;
        logic                 w_valid;
        logic [BUSW-1:0]      w_data;
        logic [BUSB-1:0]      w_strb;
        logic                 w_last;
        logic                 b_ready;
        logic                 ar_valid;
        logic [ABITS-1:0]     ar_addr;
        logic [7:0]           ar_len;
        logic [1:0]           ar_burst;
        logic [ID_BITS-1:0]   ar_id;
        logic [USER_BITS-1:0] ar_user;
        logic                 r_ready;
    } axi4_slave_in_type;

    typedef struct packed {
        logic                 aw_ready;
        logic                 w_ready;
        logic                 ar_ready;
        logic                 b_valid;
        logic [1:0]           b_resp;
        logic [ID_BITS-1:0]   b_id;
        logic [USER_BITS-1:0] b_user;
        logic                 r_valid;
        logic [1:0]           r_resp;
        logic [BUSW-1:0]      r_data;
        logic                 r_last;
        logic [ID_BITS-1:0]   r_id;
        logic [USER_BITS-1:0] r_user;
    } axi4_slave_out_type;

    // beat_cnt is one bit wider than len so a beat past len+1 is detectable
    typedef struct packed {
        state_t               state;
        logic [ABITS-1:0]     req_addr;
        logic                 req_write;
        logic [ID_BITS-1:0]   id;
        logic [USER_BITS-1:0] user;
        logic [7:0]           len;
        logic [IDX_BITS-1:0]  start_idx;
        logic [IDX_BITS-1:0]  beat_idx;
        logic [8:0]           beat_cnt;
        logic                 err;
        logic [LINEW-1:0]     line;
        logic [LINEB-1:0]     wstrb;
    } regs_t;

    localparam regs_t REGS_RST = '0;

    // True when a burst starting at slot start with len+1 beats leaves the line
    function automatic logic out_of_line(input logic [IDX_BITS-1:0] start,
                                         input logic [7:0] len);
        return (int'(start) + int'(len)) >= BURST_LEN;
    endfunction

    function automatic logic [ABITS-1:0] line_addr(input logic [ABITS-1:0] addr);
        return addr & ~ABITS'(LINEB - 1);
    endfunction

endpackage

// File: rtl/l2_line_responder_if.sv
// AXI4 slave-side bundle for the L2 line responder.
// xslvi: AW/W/AR channels plus b_ready/r_ready (driven by the master).
// xslvo: aw/w/ar ready plus B and R channels (driven by the responder).
interface l2_line_responder_if;
    import l2_line_responder_pkg::*;

    axi4_slave_in_type  xslvi;
    axi4_slave_out_type xslvo;

    modport master (output xslvi, input xslvo);
    modport slave  (input xslvi, output xslvo);
endinterface

// File: rtl/l2_line_responder.sv
// AXI4 slave that turns bursts into whole-line requests to a backing store.
// Write bursts are assembled into one line + byte strobe; read bursts fetch
// one line and stream it back beat by beat. One transaction in flight.
//
// Ports:
//   i_clk, i_nrst         clock, asynchronous active-low reset
//   xslv                  AXI4 slave channels (interface, slave modport)
//   o_req_valid/i_req_ready  line request handshake
//   o_req_write/addr/wdata/wstrb  line request payload
//   i_resp_valid/rdata/err   line response (always accepted)
//
// state        | meaning
// -------------+------------------------------------------------
// ST_IDLE      | waiting for AW (priority) or AR
// ST_WDATA     | collecting W beats into the line buffer
// ST_LINE_REQ  | line request presented until accepted
// ST_LINE_RESP | waiting for the backing-store response
// ST_BRESP     | write response presented until b_ready
// ST_RBURST    | streaming line slots out on R
module l2_line_responder
    import l2_line_responder_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_nrst,
    l2_line_responder_if.slave xslv,
    output logic              o_req_valid,
    input  logic              i_req_ready,
    output logic              o_req_write,
    output logic [ABITS-1:0]  o_req_addr,
    output logic [LINEW-1:0]  o_req_wdata,
    output logic [LINEB-1:0]  o_req_wstrb,
    input  logic              i_resp_valid,
    input  logic [LINEW-1:0]  i_resp_rdata,
    input  logic              i_resp_err
);

    regs_t              r;
    regs_t              v;
    axi4_slave_in_type  xi;
    axi4_slave_out_type xo;
    logic               unused_in;

    assign xi = xslv.xslvi;
    assign xslv.xslvo = xo;

    // Sub-beat address bits and burst type carry no meaning here: every burst is INCR.
    assign unused_in = ^{xi.aw_addr[BUS_OFS-1:0], xi.ar_addr[BUS_OFS-1:0],
                         xi.aw_burst, xi.ar_burst};

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r <= REGS_RST;
        end else begin
            r <= v;
        end
    end

    always_comb begin
        v = r;
        unique case (r.state)
            ST_IDLE: begin
                if (xi.aw_valid) begin
                    v.id        = xi.aw_id;
                    v.user      = xi.aw_user;
                    v.len       = xi.aw_len;
                    v.start_idx = xi.aw_addr[LINE_OFS-1:BUS_OFS];
                    v.beat_idx  = xi.aw_addr[LINE_OFS-1:BUS_OFS];
                    v.beat_cnt  = '0;
                    v.req_addr  = line_addr(xi.aw_addr);
                    v.req_write = 1'b1;
                    v.line      = '0;
                    v.wstrb     = '0;
                    v.err       = out_of_line(xi.aw_addr[LINE_OFS-1:BUS_OFS], xi.aw_len);
                    v.state     = ST_WDATA;
                end else if (xi.ar_valid) begin
                    v.id        = xi.ar_id;
                    v.user      = xi.ar_user;
                    v.len       = xi.ar_len;
                    v.start_idx = xi.ar_addr[LINE_OFS-1:BUS_OFS];
                    v.beat_idx  = xi.ar_addr[LINE_OFS-1:BUS_OFS];
                    v.beat_cnt  = '0;
                    v.req_addr  = line_addr(xi.ar_addr);
                    v.req_write = 1'b0;
                    v.line      = '0;
                    v.wstrb     = '0;
                    v.err       = out_of_line(xi.ar_addr[LINE_OFS-1:BUS_OFS], xi.ar_len);
                    // out-of-line reads stream zeros straight away, no line fetch
                    v.state     = v.err ? ST_RBURST : ST_LINE_REQ;
                end
            end
            ST_WDATA: begin
                if (xi.w_valid) begin
                    // once err is set nothing is written back, so drop the beat
                    if (r.err || (r.beat_cnt > {1'b0, r.len})) begin
                        v.err = 1'b1;
                    end else begin
                        v.line[int'(r.beat_idx)*BUSW +: BUSW]  = xi.w_data;
                        v.wstrb[int'(r.beat_idx)*BUSB +: BUSB] = xi.w_strb;
                    end
                    v.beat_idx = r.beat_idx + 1'b1;
                    if (r.beat_cnt != '1) begin
                        v.beat_cnt = r.beat_cnt + 1'b1;
                    end
                    if (xi.w_last) begin
                        v.state = v.err ? ST_BRESP : ST_LINE_REQ;
                    end
                end
            end
            ST_LINE_REQ: begin
                if (i_req_ready) begin
                    v.state = ST_LINE_RESP;
                end
            end
            ST_LINE_RESP: begin
                if (i_resp_valid) begin
                    v.err = r.err | i_resp_err;
                    if (r.req_write) begin
                        v.state = ST_BRESP;
                    end else begin
                        v.line     = i_resp_rdata;
                        v.beat_idx = r.start_idx;
                        v.beat_cnt = '0;
                        v.state    = ST_RBURST;
                    end
                end
            end
            ST_BRESP: begin
                if (xi.b_ready) begin
                    v.state = ST_IDLE;
                end
            end
            ST_RBURST: begin
                if (xi.r_ready) begin
                    v.beat_idx = r.beat_idx + 1'b1;
                    v.beat_cnt = r.beat_cnt + 1'b1;
                    if (r.beat_cnt == {1'b0, r.len}) begin
                        v.state = ST_IDLE;
                    end
                end
            end
            default: begin
                v = REGS_RST;
            end
        endcase
    end

    always_comb begin
        xo          = '0;
        // readies are gated by reset so every output reads 0 while held in reset
        xo.aw_ready = (r.state == ST_IDLE) && i_nrst;
        xo.ar_ready = (r.state == ST_IDLE) && i_nrst && !xi.aw_valid;
        xo.w_ready  = (r.state == ST_WDATA);
        xo.b_valid  = (r.state == ST_BRESP);
        xo.b_resp   = r.err ? RESP_SLVERR : RESP_OKAY;
        xo.b_id     = r.id;
        xo.b_user   = r.user;
        xo.r_valid  = (r.state == ST_RBURST);
        if (r.state == ST_RBURST) begin
            xo.r_data = r.line[int'(r.beat_idx)*BUSW +: BUSW];
            xo.r_last = (r.beat_cnt == {1'b0, r.len});
        end
        xo.r_resp   = r.err ? RESP_SLVERR : RESP_OKAY;
        xo.r_id     = r.id;
        xo.r_user   = r.user;
        o_req_valid = (r.state == ST_LINE_REQ);
        o_req_write = r.req_write;
        o_req_addr  = r.req_addr;
        o_req_wdata = r.line;
        o_req_wstrb = r.wstrb;
    end

endmodule
